// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result interface: bus width and the
// bit positions of the four status flags inside a packed result word.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned FLG_W  = 4;

    localparam int unsigned FLG_ZERO = 0;
    localparam int unsigned FLG_OF   = 1;
    localparam int unsigned FLG_UN   = 2;
    localparam int unsigned FLG_ERR  = 3;

    localparam int unsigned WORD_W = DATA_W + FLG_W;

endpackage

// File: rtl/alu_result_collector_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides.
// Readiness depends only on occupancy, so a full FIFO refuses a push even when popped.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Gate the head so stale or never-written entries cannot leak out.
    assign out_data  = out_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU result words into a FIFO and keeps sticky flags plus
// saturating event counters for every accepted word.
module alu_result_collector #(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_out,
    input  logic              in_of,
    input  logic              in_un,
    input  logic              in_err,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W+3:0] out_data,
    input  logic              clr,
    output logic [3:0]        sticky,
    output logic [CNT_W-1:0]  op_cnt,
    output logic [CNT_W-1:0]  of_cnt,
    output logic [CNT_W-1:0]  un_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    import alu_pkg::*;

    logic [FLG_W-1:0] flags;
    logic             push;

    always_comb begin
        flags           = '0;
        flags[FLG_ZERO] = in_zero;
        flags[FLG_OF]   = in_of;
        flags[FLG_UN]   = in_un;
        flags[FLG_ERR]  = in_err;
    end

    assign push = in_valid & in_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + FLG_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({flags, in_out}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // clr wins over a same-cycle push: that word's stats are discarded.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sticky  <= '0;
            op_cnt  <= '0;
            of_cnt  <= '0;
            un_cnt  <= '0;
            err_cnt <= '0;
        end else if (push) begin
            sticky <= sticky | flags;
            if (op_cnt != '1) begin
                op_cnt <= op_cnt + 1'b1;
            end
            if (flags[FLG_OF] && of_cnt != '1) begin
                of_cnt <= of_cnt + 1'b1;
            end
            if (flags[FLG_UN] && un_cnt != '1) begin
                un_cnt <= un_cnt + 1'b1;
            end
            if (flags[FLG_ERR] && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomized and directed checks of alu_result_collector against a queue-based model.
module tb_alu_result_collector;

    localparam int DEPTH  = 4;
    localparam int CMAX   = 255;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_out;
    logic       in_of;
    logic       in_un;
    logic       in_err;
    logic       in_zero;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       clr;
    logic [3:0] sticky;
    logic [7:0] op_cnt;
    logic [7:0] of_cnt;
    logic [7:0] un_cnt;
    logic [7:0] err_cnt;

    alu_result_collector #(
        .DATA_W (4),
        .DEPTH  (DEPTH),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_out    (in_out),
        .in_of     (in_of),
        .in_un     (in_un),
        .in_err    (in_err),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .clr       (clr),
        .sticky    (sticky),
        .op_cnt    (op_cnt),
        .of_cnt    (of_cnt),
        .un_cnt    (un_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    int m_sticky;
    int m_op;
    int m_of;
    int m_un;
    int m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_sticky = 0;
        m_op = 0;
        m_of = 0;
        m_un = 0;
        m_err = 0;
    endtask

    task automatic check_all();
        check("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("out_data",  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check("sticky",    32'(sticky),    32'(m_sticky));
        check("op_cnt",    32'(op_cnt),    32'(m_op));
        check("of_cnt",    32'(of_cnt),    32'(m_of));
        check("un_cnt",    32'(un_cnt),    32'(m_un));
        check("err_cnt",   32'(err_cnt),   32'(m_err));
    endtask

    // Check current outputs, then advance one clock and update the model.
    task automatic tick();
        logic       push;
        logic       pop;
        logic [7:0] word;
        check_all();
        push = in_valid && (mq.size() != DEPTH);
        pop  = out_ready && (mq.size() != 0);
        word = {in_err, in_un, in_of, in_zero, in_out};
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(word);
            if (clr) begin
                m_sticky = 0;
                m_op = 0;
                m_of = 0;
                m_un = 0;
                m_err = 0;
            end else if (push) begin
                m_sticky = m_sticky | int'(word[7:4]);
                m_op = sat(m_op);
                if (in_of)  m_of  = sat(m_of);
                if (in_un)  m_un  = sat(m_un);
                if (in_err) m_err = sat(m_err);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic o, input logic u,
                         input logic e, input logic z);
        in_valid = v;
        in_out   = d;
        in_of    = o;
        in_un    = u;
        in_err   = e;
        in_zero  = z;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        tick();

        // Single push with overflow flag
        drive(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("first_data", 32'(out_data), 32'h25);
        check("first_op", 32'(op_cnt), 32'd1);
        check("first_of", 32'(of_cnt), 32'd1);
        check("first_sticky", 32'(sticky), 32'h2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Five pushes into a four-deep FIFO
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i + 3), 1'(i & 1), 1'(i == 2), 1'b0, 1'(i == 4));
            tick();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);

        // Push and pop while full: only the pop happens
        drive(1'b1, 4'hf, 1'b0, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        check("full_pp_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();

        // Saturation of op_cnt and err_cnt
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("sat_err", 32'(err_cnt), 32'd255);
        check("sat_op", 32'(op_cnt), 32'd255);

        // clr beats a same-cycle push's stats but the word still enters
        out_ready = 1'b0;
        clr = 1'b1;
        drive(1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        clr = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("clr_of", 32'(of_cnt), 32'd0);
        check("clr_sticky", 32'(sticky), 32'd0);
        check("clr_word", 32'(out_data), 32'h29);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset with three words buffered
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 8), 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_op", 32'(op_cnt), 32'd0);
        check("rst_mid_un", 32'(un_cnt), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            clr = 1'($urandom_range(0, 15) == 0);
            rst = 1'($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;
        clr = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
